// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and uart_tx.
//   uart_rx_state_t : receiver FSM states
//   UART_DATA_BITS  : payload bits per frame
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset; both flops load RESET_VAL
//   d    - asynchronous input
//   q    - synchronized output, two clocks of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling at CLKS_PER_BIT oversampling.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial line, idle high
//   data      - last correctly framed byte, held until the next good byte
//   valid     - one-cycle strobe when data is new
//   frame_err - one-cycle strobe when the stop bit was sampled low
//   busy      - high whenever the receiver is not idle
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit to confirm it is still low
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit, then strobe valid or frame_err
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    uart_rx_state_t            state;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      rx_s;
    logic                      rx_prev;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            rx_prev   <= 1'b1;
        end else begin
            rx_prev   <= rx_s;
            valid     <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    // Edge rather than level: a line stuck low after a framing
                    // error must go high before another frame can start.
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        // Right shift so the LSB-first stream lands in order.
                        shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        // Leaving at mid stop bit leaves half a bit to catch
                        // a back-to-back start edge.
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int LAT  = 2 + CPB / 2 + 9 * CPB;  // edge k to stop-sample edge

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller is at a negedge; the next posedge is edge k.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        exp_t e;
        e.err  = ~stop_bit;
        e.data = stop_bit ? b : last_good;
        e.cyc  = cyc + 1 + LAT;
        sb.push_back(e);
        if (stop_bit) last_good = b;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (valid || frame_err)) begin
            if (valid && frame_err) check("valid_and_frame_err", 1, 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=0x%0h at cycle %0d, none expected",
                         valid, frame_err, data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind_err", int'(frame_err), int'(e.err));
                check("strobe_data", int'(data), int'(e.data));
                check("strobe_cycle", cyc, e.cyc);
                check("busy_at_strobe", int'(busy), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int waited;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_data", int'(data), 8'h00);
        check("reset_valid", int'(valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        repeat (200) @(negedge clk);

        // Single byte
        send_frame(8'hA5, 1'b1);
        repeat (30) @(negedge clk);

        // Back-to-back
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (30) @(negedge clk);

        // False start: low for 5 cycles
        bc = 0;
        rx = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 4) rx = 1'b1;
            if (busy) bc++;
        end
        check("false_start_busy_cycles", bc, 8);
        check("false_start_data", int'(data), 8'hFF);

        // Framing error, then recovery
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("after_ferr_busy", int'(busy), 0);
        send_frame(8'h81, 1'b1);
        repeat (30) @(negedge clk);

        // Reset during data bit 4 of 0x55
        begin
            logic [7:0] b;
            b  = 8'h55;
            rx = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rx = b[i];
                repeat (CPB) @(negedge clk);
            end
            rx = b[4];
            repeat (CPB / 2) @(negedge clk);
            check("mid_frame_busy", int'(busy), 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            rx  = 1'b1;
            check("post_reset_busy", int'(busy), 0);
            check("post_reset_data", int'(data), 8'h00);
            last_good = 8'h00;
        end
        repeat (100) @(negedge clk);
        check("idle_after_reset_busy", int'(busy), 0);
        send_frame(8'h12, 1'b1);

        waited = 0;
        while (sb.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_strobe: got none, expected err=%0b data=0x%0h at cycle %0d",
                     e.err, e.data, e.cyc);
        end
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity. It oversamples the asynchronous `rx` line at `CLKS_PER_BIT` clocks per bit and takes each bit at mid-bit. Each good byte is presented with a one-cycle `valid` strobe. It is the receive-side counterpart to the `uart_tx` block and sits between the board-level serial pin and byte-oriented logic.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Legal values are even and ≥ 4. `HALF` = `CLKS_PER_BIT/2`.
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line; idle is high.
- `data`  output  8  last correctly framed byte; holds until the next good byte.
- `valid`  output  1  one-cycle strobe; `data` is new this cycle.
- `frame_err`  output  1  one-cycle strobe; the stop bit was sampled low.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- Synchronizer: `rx` → `rx_meta` → `rx_s`. `rx_prev` is a register of `rx_s`. All decisions use `rx_s` only.
- Reset values: state IDLE; `cnt` 0; `bit_idx` 0; `shift` 0; `data` 0x00; `valid` 0; `frame_err` 0; `busy` 0; `rx_meta`, `rx_s`, `rx_prev` all 1.
- Reset asserted mid-frame abandons the frame. No strobe is issued for it.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: a falling edge (`rx_prev`=1, `rx_s`=0) moves to START with `cnt`=0. A line that is merely held low does not trigger.
  - START: count to `cnt`=`HALF`-1, then sample `rx_s`.
    - If 0: go to DATA with `cnt`=0 and `bit_idx`=0.
    - If 1 (glitch or false start): return to IDLE with no strobe.
  - DATA: at `cnt`=`CLKS_PER_BIT`-1, shift `rx_s` into `shift[7]` (right shift, so LSB-first bits end up in order) and reset `cnt` to 0.
    - After `bit_idx`=7 is sampled, go to STOP. Otherwise increment `bit_idx`.
  - STOP: at `cnt`=`CLKS_PER_BIT`-1, sample `rx_s`, then go to IDLE.
    - 1: `data` ← `shift` and `valid` ← 1.
    - 0: `frame_err` ← 1 and `data` is unchanged.
- Returning to IDLE at mid-stop-bit lets a back-to-back start bit be detected.
- After a framing error, IDLE does not re-arm until `rx_s` has been high for at least one cycle. The edge rule enforces this.
- `valid` and `frame_err` are mutually exclusive and never asserted on consecutive cycles for one frame.
- `cnt` is `$clog2(CLKS_PER_BIT)` bits wide and never wraps past `CLKS_PER_BIT`-1.

## Timing
- Let edge k be the first clock edge that sees `rx` low.
  - `rx_s` is low after edge k+1.
  - State is START after edge k+2.
- Start bit is sampled at edge k+2+`HALF`.
- Data bit i (0..7) is sampled at edge k+2+`HALF`+(i+1)·`CLKS_PER_BIT`.
- Stop bit is sampled at edge k+2+`HALF`+9·`CLKS_PER_BIT`. `valid` or `frame_err` is high for exactly the following cycle.
- `busy` rises after edge k+2 and falls after the stop-sample edge.
- No input handshake and no backpressure. A consumer must capture `data` on `valid`. `data` stays stable until the next `valid`.
- Throughput: one byte per 10·`CLKS_PER_BIT` clocks at a matched baud rate. Tolerates about ±4% baud mismatch at `CLKS_PER_BIT`=16.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` {IDLE, START, DATA, STOP};
  - `UART_DATA_BITS` = 8.
  - `uart_tx` also uses these.
- Sub-module `sync_2ff` (1-bit two-flop synchronizer with a reset value parameter, set to 1 here). It is reusable for other async inputs.
- The remaining FSM, counters and shift register stay in `uart_rx`.

## Test plan
Bench uses `CLKS_PER_BIT`=16 with an ideal serial driver.
- Reset for 3 cycles with `rx`=1 → `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0. Then 200 idle cycles → no strobes.
- Send 0xA5 → `valid` is high for one cycle at edge k+2+8+144, `data`=0xA5, `busy` falls the same cycle.
- Send 0x00 then 0xFF back-to-back (stop bit immediately followed by start) → two `valid` strobes 160 clocks apart, `data`=0x00 then 0xFF.
- Drive `rx` low for 5 cycles then high → START aborts at the mid-bit sample, `busy` pulses for 8 cycles, no strobe, `data` unchanged.
- Send 0x3C with the stop bit held low, then release `rx` high 40 cycles later and send 0x81 → one `frame_err` strobe, `data` keeps its previous value, then `valid` with `data`=0x81.
- Assert `rst` for one cycle during data bit 4 of 0x55 → no strobe, state IDLE. The next frame, 0x12, is received correctly.
